// File: rtl/meas_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | meas_pkg: shared state encoding and mode helpers for the PUF          |
// | measurement sequencer.                       Revision: 1.0            |
// +----------------------------------------------------------------------+
package meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST_PH  = 3'd1,
    ST_MEAS_PH = 3'd2,
    ST_FREE    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int unsigned MODE_SWEEP = 0;

  // Free-running mode is the all-ones code of the mode field.
  function automatic int unsigned mode_free(input int unsigned mode_bits);
    return (32'd1 << mode_bits) - 32'd1;
  endfunction

  function automatic logic mode_legal(input int unsigned mode,
                                      input int unsigned mode_bits,
                                      input int unsigned num_ch);
    return (mode == MODE_SWEEP) || (mode <= num_ch) ||
           (mode == mode_free(mode_bits));
  endfunction

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/meas_win_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | meas_win_timer: loadable down-counter that flags terminal count at 0  |
// | and never wraps.                             Revision: 1.0            |
// +----------------------------------------------------------------------+
module meas_win_timer #(
  parameter int CNT_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 tc
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule
`default_nettype wire

// File: rtl/meas_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | meas_seq_ctrl: per-channel measurement-reset sequencer with sweep,    |
// | single-channel and free-running modes.       Revision: 1.0            |
// +----------------------------------------------------------------------+
module meas_seq_ctrl
  import meas_pkg::*;
#(
  parameter int MODE_BITS = 3,
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 20,
  parameter int REP_WIDTH = 8
) (
  input  logic                          I_clk,
  input  logic                          I_rst,
  input  logic                          I_en,
  input  logic                          I_start,
  input  logic [MODE_BITS-1:0]          I_mode,
  input  logic [CNT_WIDTH-1:0]          I_window,
  input  logic [REP_WIDTH-1:0]          I_reps,
  output logic [NUM_CH-1:0]             O_meas_rst,
  output logic [ch_width(NUM_CH)-1:0]   O_ch_sel,
  output logic                          O_busy,
  output logic                          O_ready,
  output logic                          O_done,
  output logic                          O_error
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t                state, state_n;
  logic                  start_q;
  logic [CH_W-1:0]       ch, ch_n;
  logic [REP_WIDTH-1:0]  rep, rep_n;
  logic                  tog, tog_n;
  logic                  sweep_q, sweep_n;
  logic [CNT_WIDTH-1:0]  win_q, win_n;
  logic [REP_WIDTH-1:0]  rlast_q, rlast_n;
  logic                  error_n;
  logic [NUM_CH-1:0]     meas_rst_n;
  logic                  busy_n;

  logic                  start_edge;
  logic                  start_legal;
  logic                  start_free;
  logic                  tc;
  logic                  load;
  logic                  timer_en;
  logic [CNT_WIDTH-1:0]  load_val;

  assign start_edge  = I_start & ~start_q;
  assign start_free  = (32'(I_mode) == mode_free(MODE_BITS));
  assign start_legal = mode_legal(32'(I_mode), MODE_BITS, NUM_CH) && (I_window != '0);
  // In IDLE the config is not latched yet, so the first window comes straight from the port.
  assign load_val    = ((state == ST_IDLE) ? I_window : win_q) - CNT_WIDTH'(1);
  assign timer_en    = (state == ST_RST_PH) || (state == ST_MEAS_PH) || (state == ST_FREE);

  meas_win_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk      (I_clk),
    .rst      (I_rst),
    .load     (load),
    .en       (timer_en),
    .load_val (load_val),
    .tc       (tc)
  );

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state      <= ST_IDLE;
      start_q    <= 1'b0;
      ch         <= '0;
      rep        <= '0;
      tog        <= 1'b0;
      sweep_q    <= 1'b0;
      win_q      <= '0;
      rlast_q    <= '0;
      O_meas_rst <= '0;
      O_ch_sel   <= '0;
      O_busy     <= 1'b0;
      O_ready    <= 1'b1;
      O_done     <= 1'b0;
      O_error    <= 1'b0;
    end else begin
      state      <= state_n;
      start_q    <= I_start;
      ch         <= ch_n;
      rep        <= rep_n;
      tog        <= tog_n;
      sweep_q    <= sweep_n;
      win_q      <= win_n;
      rlast_q    <= rlast_n;
      O_meas_rst <= meas_rst_n;
      O_ch_sel   <= ch_n;
      O_busy     <= busy_n;
      O_ready    <= (state_n == ST_IDLE);
      O_done     <= (state_n == ST_DONE);
      O_error    <= error_n;
    end
  end

  always_comb begin
    state_n = state;
    ch_n    = ch;
    rep_n   = rep;
    tog_n   = tog;
    sweep_n = sweep_q;
    win_n   = win_q;
    rlast_n = rlast_q;
    load    = 1'b0;
    error_n = 1'b0;
    if (!I_en) begin
      state_n = ST_IDLE;
      ch_n    = '0;
      rep_n   = '0;
      tog_n   = 1'b0;
      sweep_n = 1'b0;
      win_n   = '0;
      rlast_n = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_edge) begin
            if (!start_legal) begin
              error_n = 1'b1;
            end else begin
              win_n   = I_window;
              rlast_n = (I_reps == '0) ? '0 : I_reps - REP_WIDTH'(1);
              rep_n   = '0;
              load    = 1'b1;
              if (start_free) begin
                state_n = ST_FREE;
                tog_n   = 1'b1;
                ch_n    = '0;
              end else begin
                state_n = ST_RST_PH;
                sweep_n = (32'(I_mode) == MODE_SWEEP);
                ch_n    = (32'(I_mode) == MODE_SWEEP) ? '0 : CH_W'(I_mode - MODE_BITS'(1));
              end
            end
          end
        end
        ST_RST_PH: begin
          if (tc) begin
            state_n = ST_MEAS_PH;
            load    = 1'b1;
          end
        end
        ST_MEAS_PH: begin
          if (tc) begin
            // Next channel re-enters RST_PH directly so sweeps stay back-to-back.
            if (rep != rlast_q) begin
              rep_n   = rep + REP_WIDTH'(1);
              state_n = ST_RST_PH;
              load    = 1'b1;
            end else if (sweep_q && (ch != LAST_CH)) begin
              ch_n    = ch + CH_W'(1);
              rep_n   = '0;
              state_n = ST_RST_PH;
              load    = 1'b1;
            end else begin
              state_n = ST_DONE;
            end
          end
        end
        ST_FREE: begin
          if (!I_start) begin
            state_n = ST_DONE;
            tog_n   = 1'b0;
          end else if (tc) begin
            tog_n = ~tog;
            load  = 1'b1;
          end
        end
        ST_DONE: begin
          state_n = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    meas_rst_n = '0;
    busy_n     = 1'b0;
    case (state_n)
      ST_RST_PH: begin
        meas_rst_n = NUM_CH'(1) << ch_n;
        busy_n     = 1'b1;
      end
      ST_MEAS_PH: busy_n = 1'b1;
      ST_FREE: begin
        meas_rst_n = {NUM_CH{tog_n}};
        busy_n     = 1'b1;
      end
      default: begin
        meas_rst_n = '0;
        busy_n     = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_meas_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_meas_seq_ctrl: self-checking bench for meas_seq_ctrl.              |
// |                                              Revision: 1.0            |
// +----------------------------------------------------------------------+
module tb_meas_seq_ctrl;

  localparam int MB  = 3;
  localparam int NCH = 4;
  localparam int CW  = 20;
  localparam int RW  = 8;
  localparam int CHW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, en, start;
  logic [MB-1:0]  mode;
  logic [CW-1:0]  window;
  logic [RW-1:0]  reps;
  logic [NCH-1:0] meas_rst;
  logic [CHW-1:0] ch_sel;
  logic           busy, ready, done, error;

  meas_seq_ctrl #(
    .MODE_BITS (MB),
    .NUM_CH    (NCH),
    .CNT_WIDTH (CW),
    .REP_WIDTH (RW)
  ) dut (
    .I_clk      (clk),
    .I_rst      (rst),
    .I_en       (en),
    .I_start    (start),
    .I_mode     (mode),
    .I_window   (window),
    .I_reps     (reps),
    .O_meas_rst (meas_rst),
    .O_ch_sel   (ch_sel),
    .O_busy     (busy),
    .O_ready    (ready),
    .O_done     (done),
    .O_error    (error)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int mode;
    int w;
    int r;
    bit poke;
    int exp_busy;
    int exp_err;
  } vec_t;

  vec_t tbl[9];

  // Output vector layout: {meas_rst[3:0], busy, ready, done, error}
  function automatic logic [7:0] obs();
    return {meas_rst, busy, ready, done, error};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal_mode(int m);
    return (m == 0) || (m >= 1 && m <= NCH) || (m == (1 << MB) - 1);
  endfunction

  function automatic int run_len(int m, int w, int r);
    int reff;
    if (!legal_mode(m) || w == 0 || m == (1 << MB) - 1) return 0;
    reff = (r == 0) ? 1 : r;
    return ((m == 0) ? NCH : 1) * reff * 2 * w;
  endfunction

  function automatic int exp_ch(int m, int w, int r, int k);
    int total;
    total = run_len(m, w, r);
    if (m != 0) return m - 1;
    return (k - 1) / (total / NCH);
  endfunction

  // Expected sample k cycles after the start edge (k >= 1).
  function automatic logic [7:0] exp_vec(int m, int w, int r, int k);
    int total;
    logic [7:0] v;
    total = run_len(m, w, r);
    if (total == 0) return (k == 1) ? 8'h05 : 8'h04;
    if (k <= total) begin
      v = 8'h08;
      if (((k - 1) % (2 * w)) < w) v[4 + exp_ch(m, w, r, k)] = 1'b1;
      return v;
    end
    if (k == total + 1) return 8'h02;
    return 8'h04;
  endfunction

  task automatic run_case(input int m, input int w, input int r, input bit poke,
                          input int exp_busy, input int exp_err, input string tag);
    int total, kmax, nbusy, ndone, nerr;
    total = run_len(m, w, r);
    kmax  = total + 2;
    nbusy = 0; ndone = 0; nerr = 0;
    mode   = MB'(m);
    window = CW'(w);
    reps   = RW'(r);
    start  = 1'b1;
    tick();
    for (int k = 1; k <= kmax; k++) begin
      chk({tag, "_wave"}, 32'(obs()), 32'(exp_vec(m, w, r, k)));
      if (k <= total) chk({tag, "_chsel"}, 32'(ch_sel), 32'(exp_ch(m, w, r, k)));
      nbusy += int'(busy);
      ndone += int'(done);
      nerr  += int'(error);
      start = 1'b0;
      if (poke && total >= 4 && k == 2) start = 1'b1;
      if (k == 1 && total > 0) begin
        mode   = MB'($urandom);
        window = CW'($urandom_range(1, 7));
        reps   = RW'($urandom);
      end
      if (k < kmax) tick();
    end
    chk({tag, "_busylen"}, 32'(nbusy), 32'(exp_busy));
    chk({tag, "_errcnt"}, 32'(nerr), 32'(exp_err));
    chk({tag, "_donecnt"}, 32'(ndone), 32'((exp_err != 0) ? 0 : 1));
  endtask

  initial begin
    tbl[0] = '{0, 3, 2,   1'b1, 48,  0};
    tbl[1] = '{3, 5, 1,   1'b1, 10,  0};
    tbl[2] = '{5, 3, 1,   1'b0, 0,   1};
    tbl[3] = '{0, 0, 1,   1'b0, 0,   1};
    tbl[4] = '{6, 2, 1,   1'b0, 0,   1};
    tbl[5] = '{1, 1, 0,   1'b1, 2,   0};
    tbl[6] = '{4, 2, 3,   1'b1, 12,  0};
    tbl[7] = '{0, 1, 1,   1'b1, 8,   0};
    tbl[8] = '{2, 1, 255, 1'b1, 510, 0};

    rst = 1'b1; en = 1'b1; start = 1'b0;
    mode = '0; window = '0; reps = '0;
    tick();
    tick();
    chk("reset_state", 32'({obs(), ch_sel}), 32'({8'h04, 2'b00}));
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 32'(obs()), 32'h04);

    foreach (tbl[i])
      run_case(tbl[i].mode, tbl[i].w, tbl[i].r, tbl[i].poke,
               tbl[i].exp_busy, tbl[i].exp_err, $sformatf("tbl%0d", i));

    for (int i = 0; i < 8; i++) begin
      int m, w, r, t;
      m = $urandom_range(0, 6);
      w = $urandom_range(0, 4);
      r = $urandom_range(0, 3);
      t = run_len(m, w, r);
      run_case(m, w, r, 1'b1, t, (t == 0) ? 1 : 0, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a sweep
    mode = 3'd0; window = CW'(3); reps = RW'(2); start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrun_reset1", 32'({obs(), ch_sel}), 32'({8'h04, 2'b00}));
    tick();
    chk("midrun_reset2", 32'({obs(), ch_sel}), 32'({8'h04, 2'b00}));
    rst = 1'b0;
    tick();
    chk("post_reset_idle", 32'(obs()), 32'h04);

    // Abort with I_en=0 at cycle 7 of a sweep
    mode = 3'd0; window = CW'(3); reps = RW'(2); start = 1'b1;
    tick();
    for (int k = 1; k <= 7; k++) begin
      chk("abort_prefix", 32'(obs()), 32'(exp_vec(0, 3, 2, k)));
      start = 1'b0;
      if (k < 7) tick();
    end
    en = 1'b0;
    tick();
    chk("abort_next", 32'(obs()), 32'h04);
    tick();
    chk("abort_nodone", 32'(obs()), 32'h04);
    start = 1'b1;
    tick();
    chk("start_while_disabled", 32'(obs()), 32'h04);
    start = 1'b0;
    en = 1'b1;
    tick();
    chk("still_idle", 32'(obs()), 32'h04);
    run_case(3, 5, 1, 1'b0, 10, 0, "restart");

    // Free-running mode held for 20 cycles
    mode = 3'd7; window = CW'(4); reps = RW'(1); start = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) begin
      chk("free_wave", 32'(obs()), 32'(((((k - 1) / 4) % 2) == 0) ? 8'hF8 : 8'h08));
      if (k == 1) window = CW'(2);
      if (k < 20) tick();
    end
    start = 1'b0;
    tick();
    chk("free_done", 32'(obs()), 32'h02);
    tick();
    chk("free_idle", 32'(obs()), 32'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
